// File: rtl/total_targetvol_recon.sv
// Per-phase total target voltage reconstruction: avg x min(link, P_LINK_MAX).
// One shift-add multiplier is time-shared across phases A, B and C.
module total_targetvol_recon #(
   parameter int unsigned P_LINK_MAX = 48
) (
   input  logic        i_clk_20M,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [15:0] i_Ave_TargetVolA,
   input  logic [15:0] i_Ave_TargetVolB,
   input  logic [15:0] i_Ave_TargetVolC,
   input  logic [15:0] i_LinkNumA_Work,
   input  logic [15:0] i_LinkNumB_Work,
   input  logic [15:0] i_LinkNumC_Work,
   output logic [31:0] o_TargetVolA,
   output logic [31:0] o_TargetVolB,
   output logic [31:0] o_TargetVolC,
   output logic [2:0]  o_link_clamp,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [15:0] LINK_LIM = 16'(P_LINK_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_A,
      S_MUL_B,
      S_MUL_C,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [15:0] mul_q;
   logic [15:0] avg_a_q;
   logic [15:0] avg_b_q;
   logic [15:0] avg_c_q;
   logic [15:0] link_b_q;
   logic [15:0] link_c_q;
   logic [31:0] res_a_q;
   logic [31:0] res_b_q;
   logic [31:0] res_c_q;
   logic [2:0]  flag_q;
   logic [31:0] out_a_q;
   logic [31:0] out_b_q;
   logic [31:0] out_c_q;
   logic [2:0]  clamp_q;
   logic        busy_q;
   logic        done_q;

   logic [15:0] lnk_a_c;
   logic [15:0] lnk_b_c;
   logic [15:0] lnk_c_c;
   logic [2:0]  clamp_c;
   logic [15:0] avg_c;
   logic [31:0] mcand_c;

   // Clamp the live link counts so the latched copies are already limited
   always_comb begin
      clamp_c[0] = (i_LinkNumA_Work > LINK_LIM);
      clamp_c[1] = (i_LinkNumB_Work > LINK_LIM);
      clamp_c[2] = (i_LinkNumC_Work > LINK_LIM);
      lnk_a_c    = clamp_c[0] ? LINK_LIM : i_LinkNumA_Work;
      lnk_b_c    = clamp_c[1] ? LINK_LIM : i_LinkNumB_Work;
      lnk_c_c    = clamp_c[2] ? LINK_LIM : i_LinkNumC_Work;
   end

   // Shift-add step: select the active phase average, add when multiplier LSB set
   always_comb begin
      avg_c = 16'd0;
      unique case (state_q)
         S_MUL_A: avg_c = avg_a_q;
         S_MUL_B: avg_c = avg_b_q;
         S_MUL_C: avg_c = avg_c_q;
         default: avg_c = 16'd0;
      endcase
      mcand_c = {{16{avg_c[15]}}, avg_c};
      acc_d   = mul_q[0] ? (acc_q + (mcand_c << cnt_q)) : acc_q;
   end

   // Sequencer: latch, three 16-cycle multiplies, then publish all results at once
   always_ff @(posedge i_clk_20M) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         acc_q    <= 32'd0;
         mul_q    <= 16'd0;
         avg_a_q  <= 16'd0;
         avg_b_q  <= 16'd0;
         avg_c_q  <= 16'd0;
         link_b_q <= 16'd0;
         link_c_q <= 16'd0;
         res_a_q  <= 32'd0;
         res_b_q  <= 32'd0;
         res_c_q  <= 32'd0;
         flag_q   <= 3'b000;
         out_a_q  <= 32'd0;
         out_b_q  <= 32'd0;
         out_c_q  <= 32'd0;
         clamp_q  <= 3'b000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               busy_q <= i_start;
               if (i_start) begin
                  avg_a_q  <= i_Ave_TargetVolA;
                  avg_b_q  <= i_Ave_TargetVolB;
                  avg_c_q  <= i_Ave_TargetVolC;
                  mul_q    <= lnk_a_c;
                  link_b_q <= lnk_b_c;
                  link_c_q <= lnk_c_c;
                  flag_q   <= clamp_c;
                  cnt_q    <= 4'd0;
                  acc_q    <= 32'd0;
                  state_q  <= S_MUL_A;
               end
            end
            S_MUL_A, S_MUL_B, S_MUL_C: begin
               cnt_q <= cnt_q + 4'd1;
               mul_q <= mul_q >> 1;
               acc_q <= acc_d;
               if (cnt_q == 4'd15) begin
                  acc_q <= 32'd0;
                  if (state_q == S_MUL_A) begin
                     res_a_q <= acc_d;
                     mul_q   <= link_b_q;
                     state_q <= S_MUL_B;
                  end else if (state_q == S_MUL_B) begin
                     res_b_q <= acc_d;
                     mul_q   <= link_c_q;
                     state_q <= S_MUL_C;
                  end else begin
                     res_c_q <= acc_d;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               out_a_q <= res_a_q;
               out_b_q <= res_b_q;
               out_c_q <= res_c_q;
               clamp_q <= flag_q;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_TargetVolA = out_a_q;
   assign o_TargetVolB = out_b_q;
   assign o_TargetVolC = out_c_q;
   assign o_link_clamp = clamp_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_total_targetvol_recon.sv
// Directed + randomized bench for total_targetvol_recon.
// Expected results are queued at start and popped on o_done.
module tb_total_targetvol_recon;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] avg_a, avg_b, avg_c;
   logic [15:0] lnk_a, lnk_b, lnk_c;
   logic [31:0] out_a, out_b, out_c;
   logic [2:0]  clamp;
   logic        busy;
   logic        done;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [2:0]  cl;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   total_targetvol_recon #(.P_LINK_MAX(48)) dut (
      .i_clk_20M        (clk),
      .i_reset          (rst),
      .i_start          (start),
      .i_Ave_TargetVolA (avg_a),
      .i_Ave_TargetVolB (avg_b),
      .i_Ave_TargetVolC (avg_c),
      .i_LinkNumA_Work  (lnk_a),
      .i_LinkNumB_Work  (lnk_b),
      .i_LinkNumC_Work  (lnk_c),
      .o_TargetVolA     (out_a),
      .o_TargetVolB     (out_b),
      .o_TargetVolC     (out_c),
      .o_link_clamp     (clamp),
      .o_busy           (busy),
      .o_done           (done)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)",
                  tag, $signed(obs), obs, $signed(exp), exp);
   endtask

   function automatic logic [31:0] prod(input logic [15:0] avg, input logic [15:0] lk);
      longint l;
      longint p;
      l = (lk > 16'd48) ? 48 : longint'(lk);
      p = longint'($signed(avg)) * l;
      return p[31:0];
   endfunction

   task automatic drive(input logic [15:0] a, input logic [15:0] la,
                        input logic [15:0] b, input logic [15:0] lb,
                        input logic [15:0] c, input logic [15:0] lc);
      avg_a = a; lnk_a = la;
      avg_b = b; lnk_b = lb;
      avg_c = c; lnk_c = lc;
   endtask

   task automatic push_exp();
      exp_t e;
      e.a  = prod(avg_a, lnk_a);
      e.b  = prod(avg_b, lnk_b);
      e.c  = prod(avg_c, lnk_c);
      e.cl = {lnk_c > 16'd48, lnk_b > 16'd48, lnk_a > 16'd48};
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_A"}, out_a, e.a);
         chk({tag, "_B"}, out_b, e.b);
         chk({tag, "_C"}, out_c, e.c);
         chk({tag, "_clamp"}, 32'(clamp), 32'(e.cl));
      end
   endtask

   task automatic scramble();
      drive(16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   // Inputs are set and start=1 before the call; returns #1 after the idle edge
   task automatic run_one(input string tag, input bit scr, input bit full);
      int lat;
      int busyc;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      busyc = 0;
      while (!done && lat < 60) begin
         if (busy) busyc++;
         if (scr) scramble();
         @(posedge clk); #1;
         lat++;
      end
      if (busy) busyc++;
      chk({tag, "_latency"}, 32'(lat), 32'd49);
      pop_cmp(tag);
      if (full) chk({tag, "_busy_cycles"}, 32'(busyc), 32'd50);
      @(posedge clk); #1;
      if (full) begin
         chk({tag, "_done_pulse"}, 32'(done), 32'd0);
         chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int ndone;
      int last_done;
      logic [15:0] la, lb, lc;

      rst   = 1'b1;
      start = 1'b0;
      drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_A", out_a, 32'd0);
      chk("rst_B", out_b, 32'd0);
      chk("rst_C", out_c, 32'd0);
      chk("rst_clamp", 32'(clamp), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic vector set
      drive(16'd1000, 16'd24, -16'sd500, 16'd10, 16'h8000, 16'd48);
      start = 1'b1;
      push_exp();
      chk("t1_model_A", sb[$].a, 32'd24000);
      chk("t1_model_C", sb[$].c, 32'hFFE8_0000);
      run_one("t1", 1'b0, 1'b1);
      chk("t1_B_lit", out_b, 32'hFFFF_EC78);

      // clamp and zero link
      drive(16'd100, 16'd100, 16'd7, 16'd0, 16'd32767, 16'd48);
      start = 1'b1;
      push_exp();
      run_one("t2", 1'b0, 1'b1);
      chk("t2_A_lit", out_a, 32'd4800);
      chk("t2_C_lit", out_c, 32'd1572816);
      chk("t2_clamp_lit", 32'(clamp), 32'd1);

      // re-pulses at 5 and 49 ignored, start at 50 accepted
      drive(-16'sd3, 16'd49, 16'd2, 16'd47, 16'd11, 16'd65535);
      start = 1'b1;
      push_exp();
      @(posedge clk); #1;
      start     = 1'b0;
      ndone     = 0;
      last_done = -1;
      for (int cyc = 0; cyc < 110; cyc++) begin
         if (done) begin
            ndone++;
            last_done = cyc;
            pop_cmp("t3");
         end
         start = (cyc + 1 == 5) || (cyc + 1 == 49) || (cyc + 1 == 50);
         if (cyc + 1 == 50) begin
            drive(16'd300, 16'd3, -16'sd1, 16'd1000, 16'd9, 16'd9);
            push_exp();
         end else begin
            scramble();
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("t3_done_count", 32'(ndone), 32'd2);
      chk("t3_second_done_cycle", 32'(last_done), 32'd99);
      sb.delete();

      // reset mid-computation
      drive(16'd5, 16'd5, 16'd6, 16'd6, 16'd7, 16'd7);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_A_zero", out_a, 32'd0);
      chk("t4_B_zero", out_b, 32'd0);
      chk("t4_C_zero", out_c, 32'd0);
      chk("t4_clamp_zero", 32'(clamp), 32'd0);
      chk("t4_busy_low", 32'(busy), 32'd0);
      ndone = 0;
      repeat (60) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      chk("t4_no_done", 32'(ndone), 32'd0);

      // start coincident with reset is dropped
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk("t5_busy_low", 32'(busy), 32'd0);

      // fresh start after reset
      drive(-16'sd1234, 16'd37, 16'd77, 16'd48, -16'sd32768, 16'd49);
      start = 1'b1;
      push_exp();
      run_one("t6", 1'b0, 1'b1);

      // randomized, inputs scrambled every cycle after acceptance
      for (int r = 0; r < 1000; r++) begin
         la = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 60)) : 16'($urandom);
         lb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 60)) : 16'($urandom);
         lc = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 60)) : 16'($urandom);
         drive(16'($urandom), la, 16'($urandom), lb, 16'($urandom), lc);
         start = 1'b1;
         push_exp();
         run_one("rnd", 1'b1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/total_targetvol_recon.md
# total_targetvol_recon

Sequential reconstruction of per-phase total target voltage from the per-cell average target voltage and the working link count: product = average × link count, for phases A, B and C. It is the inverse path of the per-phase average-voltage divider. It sits in the VCU control datapath wherever a per-cell setpoint must be turned back into a phase-level quantity, such as redundancy reconfiguration or readback. One time-shared shift-add multiplier serves all three phases under a start/done handshake.

## Interface
Parameters:
- P_LINK_MAX, 48, maximum permitted working link count per phase; larger inputs are clamped to this value.

Ports:
- i_clk_20M  in  1  system clock, 20 MHz
- i_reset  in  1  reset, synchronous, active-high
- i_start  in  1  single-cycle request; sampled only in IDLE
- i_Ave_TargetVolA  in  16  signed average cell target voltage, phase A
- i_Ave_TargetVolB  in  16  signed, phase B
- i_Ave_TargetVolC  in  16  signed, phase C
- i_LinkNumA_Work  in  16  unsigned working link count, phase A
- i_LinkNumB_Work  in  16  unsigned, phase B
- i_LinkNumC_Work  in  16  unsigned, phase C
- o_TargetVolA  out  32  signed reconstructed total, phase A
- o_TargetVolB  out  32  signed, phase B
- o_TargetVolC  out  32  signed, phase C
- o_link_clamp  out  3  bit0/1/2 = link count of A/B/C was clamped in the last computation
- o_busy  out  1  high from the cycle after start is accepted until o_done
- o_done  out  1  one-cycle pulse; outputs are valid and updated on this cycle

Clock and reset: one clock, i_clk_20M. Reset is synchronous and active-high, on i_reset.

## Operation
- FSM states: IDLE, MUL_A, MUL_B, MUL_C, DONE.
- IDLE:
  - When i_start=1, latch all six data inputs into shadow registers.
  - Apply the clamp: link = min(link, P_LINK_MAX). Set the corresponding clamp bit into a pending-flag register.
  - Go to MUL_A.
- MUL_x, 16 cycles each, driven by a 4-bit iteration counter:
  - Multiplicand is the average, sign-extended to 32 bits.
  - Multiplier is the clamped link count, unsigned.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand (shifted left by the counter) into a 32-bit accumulator. Then shift the multiplier right.
  - At counter=15, store the accumulator into that phase's pending result, clear the accumulator, and advance A→B→C→DONE.
- Width: a signed 16 × unsigned 16 product always fits in signed 32 bits (worst case −32768×65535 = −2147450880). No saturation logic is needed. Arithmetic is two's complement, mod 2^32.
- DONE:
  - Copy the three pending results to o_TargetVolA/B/C, copy the pending flags to o_link_clamp, pulse o_done, and return to IDLE.
  - All three outputs update on the same edge. Between computations they hold their last values.
- i_start while not in IDLE (including the DONE cycle) is ignored and not queued.
- Inputs may change freely after acceptance; only the latched copies are used.
- Link count 0 yields a result of 0 with no flag.

## Timing
- Reset values: all outputs 0, o_link_clamp = 3'b000, FSM = IDLE, accumulator and counter = 0.
- Edge-by-edge sequence, with edge 0 being the edge that samples i_start=1 in IDLE:
  - o_busy goes high after edge 0.
  - MUL_A occupies edges 1–16, MUL_B edges 17–32, MUL_C edges 33–48.
  - DONE is entered at edge 49: outputs update and o_done=1 for exactly one cycle; o_busy stays high during that cycle.
  - o_busy=0 and IDLE after edge 50.
- Fixed latency: 49 cycles from the start-sampling edge to o_done. The earliest next accepted start is at edge 50, giving a throughput of 1 result set per 50 cycles.
- Reset mid-operation takes priority over all state. The next edge forces IDLE, zeroes all outputs and flags, and produces no o_done.
- i_start and i_reset high on the same edge: reset wins and the start is dropped.

## Test plan
- A=1000/link 24, B=−500/link 10, C=−32768/link 48, single start → o_done exactly 49 cycles later; outputs 24000, −5000, −1572864; o_link_clamp=000; o_busy high for 50 cycles.
- A=100/link 100 (P_LINK_MAX=48), B=7/link 0, C=32767/link 48 → outputs 4800, 0, 1572816; o_link_clamp=001.
- Start accepted, then i_start re-pulsed at cycles 5 and 49 → only one o_done; a third start at cycle 50 is accepted and its o_done arrives at cycle 99.
- Input buses changed every cycle after acceptance → results match the values latched at the start edge.
- i_reset asserted at cycle 20 of a computation → all outputs 0 and o_busy=0 after that edge; no o_done; a fresh start afterwards completes normally in 49 cycles.
- Randomized signed averages, link counts 0–65535, ≥1000 runs → each output equals avg × min(link, P_LINK_MAX) exactly, and each clamp bit equals (link > P_LINK_MAX).
